// File: rtl/connect4_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : connect4_pkg                                              |
// | Description : Shared board geometry, plane type, player and win codes.  |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
package connect4_pkg;

    localparam int BOARD_ROWS = 16;
    localparam int BOARD_COLS = 16;

    typedef logic [BOARD_ROWS-1:0][BOARD_COLS-1:0] board_t;

    typedef enum logic {
        RED   = 1'b0,
        GREEN = 1'b1
    } player_t;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_RED   = 2'b01;
    localparam logic [1:0] WIN_GREEN = 2'b10;
    localparam logic [1:0] WIN_TIE   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_FALL = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/drop_timer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : drop_timer                                                |
// | Description : ANIM_TICKS prescaler; pulses o_step once per row period.  |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
module drop_timer #(
    parameter int ANIM_TICKS = 4
) (
    input  logic Clock,
    input  logic reset,
    input  logic i_enable,
    output logic o_step
);

    localparam int c_CNT_W = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(ANIM_TICKS - 1);

    logic [c_CNT_W-1:0] r_cnt;

    assign o_step = i_enable && (r_cnt == c_LAST);

    // Counter parks at zero while disabled so each fall starts a full period.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!i_enable || o_step) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/board_writer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : board_writer                                              |
// | Description : Connect-4 board owner; gravity drop, turn alternation.    |
// |               Optional falling-piece animation under DROP_ANIM_EN.      |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
module board_writer
    import connect4_pkg::*;
#(
    parameter int ANIM_TICKS = 4
) (
    input  logic             Clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             drop,
    input  logic [3:0]       col,
    input  logic [1:0]       win,
    output logic [15:0][15:0] red,
    output logic [15:0][15:0] green,
    output logic             turn,
    output logic             busy,
    output logic             drop_ok,
    output logic             drop_err,
    output logic             fall_valid,
    output logic [3:0]       fall_row,
    output logic [3:0]       fall_col
);

    if (ANIM_TICKS < 1) begin : g_bad_anim_ticks
        $error("ANIM_TICKS must be at least 1");
    end

    state_t     r_state, w_state_nxt;
    board_t     r_red, w_red_nxt;
    board_t     r_green, w_green_nxt;
    logic       r_turn, w_turn_nxt;
    logic [3:0] r_col, w_col_nxt;
    logic [3:0] r_row, w_row_nxt;
    logic       r_drop_ok, w_drop_ok_nxt;
    logic       r_drop_err, w_drop_err_nxt;
    logic       w_place;
    logic [3:0] w_place_row;
    logic       w_cell_free;

    assign w_cell_free = ~(r_red[r_row][r_col] | r_green[r_row][r_col]);

`ifdef DROP_ANIM_EN
    logic       r_fall_valid, w_fall_valid_nxt;
    logic [3:0] r_fall_row, w_fall_row_nxt;
    logic [3:0] r_target, w_target_nxt;
    logic       w_fall_en;
    logic       w_step;

    assign w_fall_en = (r_state == S_FALL);

    drop_timer #(
        .ANIM_TICKS (ANIM_TICKS)
    ) u_drop_timer (
        .Clock    (Clock),
        .reset    (reset),
        .i_enable (w_fall_en),
        .o_step   (w_step)
    );
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_red_nxt      = r_red;
        w_green_nxt    = r_green;
        w_turn_nxt     = r_turn;
        w_col_nxt      = r_col;
        w_row_nxt      = r_row;
        w_drop_ok_nxt  = 1'b0;
        w_drop_err_nxt = 1'b0;
        w_place        = 1'b0;
        w_place_row    = r_row;
`ifdef DROP_ANIM_EN
        w_fall_valid_nxt = r_fall_valid;
        w_fall_row_nxt   = r_fall_row;
        w_target_nxt     = r_target;
`endif
        if (clear) begin
            w_state_nxt = S_IDLE;
            w_red_nxt   = '0;
            w_green_nxt = '0;
            w_turn_nxt  = 1'b0;
`ifdef DROP_ANIM_EN
            w_fall_valid_nxt = 1'b0;
            w_fall_row_nxt   = '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (drop && (win == WIN_NONE)) begin
                        w_col_nxt   = col;
                        w_row_nxt   = 4'(BOARD_ROWS - 1);
                        w_state_nxt = S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_cell_free) begin
`ifdef DROP_ANIM_EN
                        // Planes stay untouched until the animation lands.
                        w_target_nxt     = r_row;
                        w_fall_valid_nxt = 1'b1;
                        w_fall_row_nxt   = '0;
                        w_state_nxt      = S_FALL;
`else
                        w_place     = 1'b1;
                        w_place_row = r_row;
                        w_state_nxt = S_IDLE;
`endif
                    end else if (r_row == 4'd0) begin
                        w_drop_err_nxt = 1'b1;
                        w_state_nxt    = S_IDLE;
                    end else begin
                        w_row_nxt = r_row - 4'd1;
                    end
                end
`ifdef DROP_ANIM_EN
                S_FALL: begin
                    if (w_step) begin
                        if (r_fall_row == r_target) begin
                            w_place          = 1'b1;
                            w_place_row      = r_target;
                            w_fall_valid_nxt = 1'b0;
                            w_fall_row_nxt   = '0;
                            w_state_nxt      = S_IDLE;
                        end else begin
                            w_fall_row_nxt = r_fall_row + 4'd1;
                        end
                    end
                end
`endif
                default: w_state_nxt = S_IDLE;
            endcase

            if (w_place) begin
                if (player_t'(r_turn) == GREEN) begin
                    w_green_nxt[w_place_row][r_col] = 1'b1;
                end else begin
                    w_red_nxt[w_place_row][r_col] = 1'b1;
                end
                w_turn_nxt    = ~r_turn;
                w_drop_ok_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_red      <= '0;
            r_green    <= '0;
            r_turn     <= 1'b0;
            r_col      <= '0;
            r_row      <= '0;
            r_drop_ok  <= 1'b0;
            r_drop_err <= 1'b0;
`ifdef DROP_ANIM_EN
            r_fall_valid <= 1'b0;
            r_fall_row   <= '0;
            r_target     <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_red      <= w_red_nxt;
            r_green    <= w_green_nxt;
            r_turn     <= w_turn_nxt;
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            r_drop_ok  <= w_drop_ok_nxt;
            r_drop_err <= w_drop_err_nxt;
`ifdef DROP_ANIM_EN
            r_fall_valid <= w_fall_valid_nxt;
            r_fall_row   <= w_fall_row_nxt;
            r_target     <= w_target_nxt;
`endif
        end
    end

    assign red      = r_red;
    assign green    = r_green;
    assign turn     = r_turn;
    assign busy     = (r_state != S_IDLE);
    assign drop_ok  = r_drop_ok;
    assign drop_err = r_drop_err;

`ifdef DROP_ANIM_EN
    assign fall_valid = r_fall_valid;
    assign fall_row   = r_fall_row;
    assign fall_col   = r_fall_valid ? r_col : 4'd0;
`else
    assign fall_valid = 1'b0;
    assign fall_row   = 4'd0;
    assign fall_col   = 4'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_board_writer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : tb_board_writer                                           |
// | Description : Self-checking bench for board_writer (DROP_ANIM_EN aware).|
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
module tb_board_writer;

    localparam int ANIM = 4;
`ifdef DROP_ANIM_EN
    localparam int ANIM_MUL = ANIM;
`else
    localparam int ANIM_MUL = 0;
`endif

    logic             Clock = 1'b0;
    logic             reset = 1'b0;
    logic             clear = 1'b0;
    logic             drop  = 1'b0;
    logic [3:0]       col   = 4'd0;
    logic [1:0]       win   = 2'b00;
    logic [15:0][15:0] red, green;
    logic             turn, busy, drop_ok, drop_err, fall_valid;
    logic [3:0]       fall_row, fall_col;

    board_writer #(.ANIM_TICKS(ANIM)) dut (
        .Clock(Clock), .reset(reset), .clear(clear), .drop(drop), .col(col), .win(win),
        .red(red), .green(green), .turn(turn), .busy(busy), .drop_ok(drop_ok),
        .drop_err(drop_err), .fall_valid(fall_valid), .fall_row(fall_row), .fall_col(fall_col)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int anim_extra(input int t);
        return (t + 1) * ANIM_MUL;
    endfunction

    // Model: occupancy planes plus a countdown to the moment the move resolves.
    logic [15:0][15:0] m_red, m_green;
    logic              m_turn;
    int                m_left;
    logic              m_is_err;
    int                m_t;
    logic [3:0]        m_col;
    logic              m_ok, m_err;
    int                m_n;

    task automatic model_reset();
        m_red = '0; m_green = '0; m_turn = 1'b0; m_left = 0;
        m_is_err = 1'b0; m_t = 0; m_col = 4'd0; m_ok = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_step();
        m_ok  = 1'b0;
        m_err = 1'b0;
        if (clear) begin
            m_red = '0; m_green = '0; m_turn = 1'b0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                if (m_is_err) begin
                    m_err = 1'b1;
                end else begin
                    if (m_turn) m_green[m_t][m_col] = 1'b1;
                    else        m_red[m_t][m_col]   = 1'b1;
                    m_turn = ~m_turn;
                    m_ok   = 1'b1;
                end
            end
        end else if (drop && win == 2'b00) begin
            m_n = 0;
            for (int r = 0; r < 16; r++) if (m_red[r][col] || m_green[r][col]) m_n++;
            m_col = col;
            if (m_n == 16) begin
                m_is_err = 1'b1;
                m_left   = 16;
            end else begin
                m_is_err = 1'b0;
                m_t      = 15 - m_n;
                m_left   = m_n + 1 + anim_extra(m_t);
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge Clock);
            if (!reset) model_reset();
            else        model_step();
        end
    end

    initial begin
        forever begin
            @(negedge Clock);
            if (reset) begin
                check("red_plane", red, m_red);
                check("green_plane", green, m_green);
                check("turn", turn, m_turn);
                check("busy", busy, m_left > 0);
                check("drop_ok", drop_ok, m_ok);
                check("drop_err", drop_err, m_err);
                check("no_overlap", red & green, '0);
`ifdef DROP_ANIM_EN
                if (m_left > 0 && !m_is_err && m_left <= (m_t + 1) * ANIM) begin
                    check("fall_valid", fall_valid, 1'b1);
                    check("fall_row", fall_row, ((m_t + 1) * ANIM - m_left) / ANIM);
                    check("fall_col", fall_col, m_col);
                end else begin
                    check("fall_valid", fall_valid, 1'b0);
                end
`else
                check("fall_valid", fall_valid, 1'b0);
                check("fall_row", fall_row, 4'd0);
                check("fall_col", fall_col, 4'd0);
`endif
            end
        end
    end

    task automatic do_drop(input logic [3:0] c, output int lat, output int bcyc, output logic ok);
        @(negedge Clock); drop = 1'b1; col = c;
        @(negedge Clock); drop = 1'b0; col = ~c;
        lat = 0; bcyc = 0;
        while (!(drop_ok || drop_err) && lat < 2000) begin
            if (busy) bcyc++;
            @(negedge Clock);
            lat++;
        end
        if (lat >= 2000) check("drop_timeout", 1'b1, 1'b0);
        ok = drop_ok;
    endtask

    int   lat, bcyc, oks;
    logic ok;

    initial begin
        repeat (3) @(negedge Clock);
        check("reset_red", red, '0);
        check("reset_green", green, '0);
        check("reset_turn", turn, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_pulses", {drop_ok, drop_err, fall_valid}, 3'b000);
        reset = 1'b1;
        @(negedge Clock);

        // Single drop into empty column 5
        do_drop(4'd5, lat, bcyc, ok);
        check("t1_ok", ok, 1'b1);
        check("t1_cell", red[15][5], 1'b1);
        check("t1_turn", turn, 1'b1);
        check("t1_lat", lat, 1 + anim_extra(15));
        check("t1_busy_cycles", bcyc, 1 + anim_extra(15));
        @(negedge Clock);
        check("t1_single_pulse", drop_ok, 1'b0);

        // New game, then stack four in column 3
        clear = 1'b1; @(negedge Clock); clear = 1'b0;
        check("clear_idle_red", red, '0);
        check("clear_idle_turn", turn, 1'b0);
        for (int k = 0; k < 4; k++) begin
            do_drop(4'd3, lat, bcyc, ok);
            check("t2_lat", lat, k + 1 + anim_extra(15 - k));
        end
        check("t2_r15", red[15][3], 1'b1);
        check("t2_g14", green[14][3], 1'b1);
        check("t2_r13", red[13][3], 1'b1);
        check("t2_g12", green[12][3], 1'b1);

        // Fill column 0, then overflow it
        for (int k = 0; k < 16; k++) begin
            do_drop(4'd0, lat, bcyc, ok);
            check("t3_fill_ok", ok, 1'b1);
            check("t3_fill_lat", lat, k + 1 + anim_extra(15 - k));
        end
        check("t3_bottom_red", red[15][0], 1'b1);
        check("t3_top_green", green[0][0], 1'b1);
        do_drop(4'd0, lat, bcyc, ok);
        check("t3_full_err", {ok, drop_err}, 2'b01);
        check("t3_full_lat", lat, 16);
        check("t3_full_turn", turn, 1'b0);

        // Drop while busy is ignored
        @(negedge Clock); drop = 1'b1; col = 4'd3;
        @(negedge Clock); drop = 1'b0; col = 4'd10;
        @(negedge Clock); drop = 1'b1;
        @(negedge Clock); drop = 1'b0;
        oks = 0;
        repeat (8 + anim_extra(11)) begin
            if (drop_ok) oks++;
            @(negedge Clock);
        end
        check("t4_one_pulse", oks, 1);
        check("t4_cell", red[11][3], 1'b1);
        check("t4_col10_empty", {red[15][10], green[15][10]}, 2'b00);

        // Drop while a win is reported is ignored
        win = 2'b01;
        @(negedge Clock); drop = 1'b1; col = 4'd10;
        @(negedge Clock); drop = 1'b0;
        check("t4_win_busy", busy, 1'b0);
        repeat (3) @(negedge Clock);
        check("t4_win_col10", {red[15][10], green[15][10]}, 2'b00);
        win = 2'b00;

        // Clear mid-SCAN on column 3 (5 pieces)
        @(negedge Clock); drop = 1'b1; col = 4'd3;
        @(negedge Clock); drop = 1'b0;
        @(negedge Clock); clear = 1'b1;
        @(negedge Clock); clear = 1'b0;
        check("t5_red", red, '0);
        check("t5_green", green, '0);
        check("t5_turn", turn, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_no_ok", drop_ok, 1'b0);
        repeat (8) @(negedge Clock);

        // Mixed play after the clear
        do_drop(4'd15, lat, bcyc, ok);
        do_drop(4'd15, lat, bcyc, ok);
        do_drop(4'd2, lat, bcyc, ok);
        check("t6_r15_15", red[15][15], 1'b1);
        check("t6_g14_15", green[14][15], 1'b1);
        check("t6_r15_2", red[15][2], 1'b1);
        check("t6_turn", turn, 1'b1);

`ifdef DROP_ANIM_EN
        clear = 1'b1; @(negedge Clock); clear = 1'b0;
        do_drop(4'd7, lat, bcyc, ok);
        check("anim_lat", lat, 65);
        check("anim_cell", red[15][7], 1'b1);
        check("anim_valid_after", fall_valid, 1'b0);
`endif

        repeat (2) @(negedge Clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/board_writer.md
Name: board_writer

Overview:
- Owns the two 16x16 occupancy planes (`red`, `green`) that the win detector reads; it is the writer side of that board interface.
- Accepts one column-drop request at a time and applies Connect-4 gravity by scanning the column bottom-up, one row per cycle.
- Writes the piece for the current player, then alternates turns.
- Freezes once the win detector reports any result other than no-win.

Parameters:
- ANIM_TICKS, 4, cycles the falling piece spends on each row (used only with DROP_ANIM_EN).

Ports:
- Clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- clear  in  1  synchronous new-game request; clears board and turn.
- drop  in  1  single-cycle drop request.
- col  in  4  target column, 0..15 (bit index within a row).
- win  in  2  win code from the detector: 00 none, 01 red, 10 green, 11 tie.
- red  out  16x16  red plane, `[row][col]`; row 15 is the bottom.
- green  out  16x16  green plane, same layout.
- turn  out  1  0 = red to move, 1 = green to move.
- busy  out  1  high whenever the state is not IDLE.
- drop_ok  out  1  one-cycle pulse when a piece is written.
- drop_err  out  1  one-cycle pulse when the drop is rejected because the column is full.
- fall_valid  out  1  falling-piece marker valid (0 when DROP_ANIM_EN is off).
- fall_row  out  4  row of the falling piece.
- fall_col  out  4  column of the falling piece.

Behaviour:
- Reset (reset=0, asynchronous): `red`, `green`, `turn`, `drop_ok`, `drop_err`, `fall_*` all 0; state IDLE.
- States: IDLE, SCAN, FALL (DROP_ANIM_EN only).
- IDLE:
  - `drop`=1 and `win`=00: latch `col` into `c_q`, set `r`=15, go to SCAN.
  - `drop` while `win`≠00 is ignored (no pulse, no write).
- SCAN, on each edge:
  - If `red[r][c_q]` and `green[r][c_q]` are both 0: set the `turn` player's bit at `[r][c_q]`, toggle `turn`, pulse `drop_ok`, return to IDLE.
  - Else if `r`=0: pulse `drop_err`, leave `turn` unchanged, return to IDLE.
  - Else: decrement `r`.
- Latency: in a column holding n pieces, the bit becomes visible n+1 edges after the accept edge. A full column gives `drop_err` 16 edges after accept.
- `drop` while `busy`=1 is ignored and not queued. `col` is only sampled on the accept edge.
- `clear` has priority over everything:
  - Zeroes both planes, sets `turn`=0, aborts SCAN/FALL with no pulse, goes to IDLE. Takes effect on the next edge.
- Invariant: a cell is never set in both planes. The bench asserts `red & green` == 0 every cycle.
- `win` is sampled only in IDLE. An in-flight drop completes even if `win` changes.
- An asynchronous reset mid-SCAN or mid-FALL discards the move.

Optional Feature:
- DROP_ANIM_EN defined:
  - SCAN records the target row `t` and enters FALL instead of writing.
  - FALL: `fall_valid`=1, `fall_col`=`c_q`, `fall_row` starts at 0 and increments every ANIM_TICKS cycles.
  - When `fall_row`=`t` and its tick count expires, the cell is written, `turn` toggles, `drop_ok` pulses and `fall_valid` drops; return to IDLE.
  - Added latency: (`t`+1)*ANIM_TICKS cycles.
  - The planes are not modified during FALL, so the win detector never sees a transient piece.
  - `drop_err` timing is unchanged.
- DROP_ANIM_EN undefined: no FALL state, `fall_*` tied to 0, ANIM_TICKS unused.

Decomposition:
- Package connect4_pkg:
  - `board_t` (logic [15:0][15:0]).
  - `player_t` enum {RED, GREEN}.
  - Win codes WIN_NONE=2'b00, WIN_RED=2'b01, WIN_GREEN=2'b10, WIN_TIE=2'b11.
  - BOARD_ROWS=16, BOARD_COLS=16.
- Sub-module drop_timer: ANIM_TICKS prescaler that emits a step pulse to advance `fall_row`. Instantiated only under DROP_ANIM_EN.

Test Plan:
- Reset, then `drop` `col`=5 → after 1 edge `red[15][5]`=1, `turn`=1, `drop_ok` pulses once; `busy` high for exactly 1 cycle.
- Four drops into `col`=3 (red, green, red, green) → `red[15][3]`, `green[14][3]`, `red[13][3]`, `green[12][3]` set; 4th write lands 4 edges after its accept.
- Fill `col`=0 with 16 drops, then a 17th → `drop_err` 16 edges after accept, `turn` unchanged, planes unchanged.
- `drop` pulsed again while `busy`, and `drop` with `win`=2'b01 → both ignored: no pulses, planes identical.
- Assert `clear` mid-SCAN on a column holding 5 pieces → next edge both planes 0, `turn`=0, no `drop_ok`.
- With DROP_ANIM_EN and ANIM_TICKS=4, drop into an empty `col`=7 → `fall_row` steps 0..15 every 4 cycles, `red[15][7]` set after 64 cycles in FALL, `fall_valid` then 0.
